ff_input_conditioner: RTL and testbench

- Front-end stage for the lab flip-flop blocks.
- Produces a periodic one-cycle `tick` clock-enable on the single system clock. This replaces the derived divided clock.
- Synchronises and debounces the raw board switch/button inputs that drive the flip-flop data inputs (S/R, J/K, D, T).
- Downstream flops then run on `clk`, update only when `tick` is high, and see clean, glitch-free levels.

---
 rtl/ff_lab_pkg.sv | 15 +
 rtl/debounce_bit.sv | 74 +++++++
 rtl/ff_input_conditioner.sv | 58 +++++
 tb/tb_ff_input_conditioner.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ff_lab_pkg.sv
// Shared constants and width helper for the lab flip-flop blocks.
//   TICK_DIV_BOARD : clk cycles per tick at the board clock (2^23)
//   DB_TICKS_DEF   : default number of ticks a new input level must persist
//   clog2_w()      : counter width for a value range 0..n-1, never below 1 bit
package ff_lab_pkg;

    localparam int unsigned TICK_DIV_BOARD = 8388608;
    localparam int unsigned DB_TICKS_DEF   = 3;

    // A range of a single value still needs one bit of storage.
    function automatic int unsigned clog2_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: 2-flop synchroniser, tick-qualified stability
// counter, debounced level and rising-edge pulse.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   tick     : shared one-cycle sampling enable
//   raw_in   : asynchronous switch/button level
//   din      : debounced level (registered)
//   din_rise : one-cycle pulse when din goes 0->1 (registered)
module debounce_bit
    import ff_lab_pkg::*;
#(
    parameter int unsigned DB_TICKS = DB_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw_in,
    output logic din,
    output logic din_rise
);

    localparam int unsigned CW = clog2_w(DB_TICKS + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_din;
    logic          r_din_rise;
    logic          w_differ;
    logic          w_accept;

    assign w_differ = (r_sync2 != r_din);
    // Last required tick of an uninterrupted run of disagreement.
    assign w_accept = w_differ && tick && (r_cnt == CW'(DB_TICKS - 1));

    // Synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: any agreement discards progress, ticks advance it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_differ || w_accept) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Debounced level and its rising-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din      <= 1'b0;
            r_din_rise <= 1'b0;
        end else begin
            r_din_rise <= w_accept && r_sync2;
            if (w_accept) begin
                r_din <= r_sync2;
            end
        end
    end

    assign din      = r_din;
    assign din_rise = r_din_rise;

endmodule

// File: rtl/ff_input_conditioner.sv
// Front-end for the lab flip-flop blocks: periodic tick enable plus
// synchronised, debounced data inputs.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   raw_in   : N_IN asynchronous switch/button levels
//   tick     : one-cycle enable, period TICK_DIV cycles
//   din      : N_IN debounced levels
//   din_rise : N_IN one-cycle 0->1 pulses
module ff_input_conditioner
    import ff_lab_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_BOARD,
    parameter int unsigned N_IN     = 2,
    parameter int unsigned DB_TICKS = DB_TICKS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] raw_in,
    output logic            tick,
    output logic [N_IN-1:0] din,
    output logic [N_IN-1:0] din_rise
);

    localparam int unsigned PW = clog2_w(TICK_DIV);

    logic [PW-1:0] r_pres;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = (r_pres == PW'(TICK_DIV - 1));

    // Prescaler; tick is registered so it lands in the cycle after the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pres <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pres <= w_wrap ? '0 : r_pres + PW'(1);
            r_tick <= w_wrap;
        end
    end

    assign tick = r_tick;

    for (genvar g = 0; g < int'(N_IN); g++) begin : g_bit
        debounce_bit #(
            .DB_TICKS (DB_TICKS)
        ) u_debounce_bit (
            .clk      (clk),
            .rst      (rst),
            .tick     (r_tick),
            .raw_in   (raw_in[g]),
            .din      (din[g]),
            .din_rise (din_rise[g])
        );
    end

endmodule

// File: tb/tb_ff_input_conditioner.sv
// Bench for ff_input_conditioner (TICK_DIV=4, N_IN=2, DB_TICKS=3).
module tb_ff_input_conditioner;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned N_IN     = 2;
    localparam int unsigned DB_TICKS = 3;

    logic            clk;
    logic            rst;
    logic [N_IN-1:0] raw_in;
    logic            tick;
    logic [N_IN-1:0] din;
    logic [N_IN-1:0] din_rise;

    int n_tests;
    int n_fail;
    int cyc;

    // Reference model state.
    int              m_since_rel;   // cycles since reset was released
    logic            m_tick;
    logic [N_IN-1:0] m_s1;
    logic [N_IN-1:0] m_s2;
    logic [N_IN-1:0] m_din;
    logic [N_IN-1:0] m_rise;
    int              m_run [N_IN];  // ticks seen during current disagreement

    ff_input_conditioner #(
        .TICK_DIV (TICK_DIV),
        .N_IN     (N_IN),
        .DB_TICKS (DB_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (raw_in),
        .tick     (tick),
        .din      (din),
        .din_rise (din_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model by one clock edge given the inputs sampled there.
    task automatic model_step(input logic r, input logic [N_IN-1:0] raw);
        logic [N_IN-1:0] nd;
        if (r) begin
            m_since_rel = 0;
            m_tick      = 1'b0;
            m_s1        = '0;
            m_s2        = '0;
            m_din       = '0;
            m_rise      = '0;
            for (int b = 0; b < int'(N_IN); b++) m_run[b] = 0;
        end else begin
            nd = m_din;
            for (int b = 0; b < int'(N_IN); b++) begin
                if (m_s2[b] == m_din[b]) begin
                    m_run[b] = 0;
                end else if (m_tick) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == int'(DB_TICKS)) begin
                        nd[b]    = m_s2[b];
                        m_run[b] = 0;
                    end
                end
            end
            m_rise      = nd & ~m_din;
            m_din       = nd;
            m_since_rel = m_since_rel + 1;
            m_tick      = (m_since_rel % int'(TICK_DIV)) == 0;
            m_s2        = m_s1;
            m_s1        = raw;
        end
    endtask

    task automatic run_cycle(input logic r, input logic [N_IN-1:0] raw);
        rst    = r;
        raw_in = raw;
        @(posedge clk);
        model_step(r, raw);
        cyc++;
        #1;
        check("tick", 32'(tick), 32'(m_tick));
        check("din", 32'(din), 32'(m_din));
        check("din_rise", 32'(din_rise), 32'(m_rise));
    endtask

    task automatic hold(input logic [N_IN-1:0] raw, input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, raw);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst     = 1'b1;
        raw_in  = '0;
        m_since_rel = 0;
        m_tick = 1'b0;
        m_s1 = '0;
        m_s2 = '0;
        m_din = '0;
        m_rise = '0;
        for (int b = 0; b < int'(N_IN); b++) m_run[b] = 0;

        // Reset, then idle: tick cadence with quiet outputs.
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 2'b00);
        hold(2'b00, 14);
        // Bit 0 rises and is held.
        hold(2'b01, 20);
        // Bit 1 bounces high for 5 cycles only.
        hold(2'b11, 5);
        hold(2'b01, 12);
        // Bit 0 falls.
        hold(2'b00, 20);
        // Both bits rise together.
        hold(2'b11, 20);
        hold(2'b00, 20);
        // Reset after partial qualification on bit 0.
        hold(2'b01, 11);
        run_cycle(1'b1, 2'b01);
        hold(2'b01, 20);
        hold(2'b00, 20);

        // Randomised levels with random hold times and occasional resets.
        for (int k = 0; k < 300; k++) begin
            logic [N_IN-1:0] v;
            v = N_IN'($urandom);
            if ($urandom_range(0, 39) == 0) run_cycle(1'b1, v);
            hold(v, int'($urandom_range(1, 18)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
